// File: rtl/seq_pkg.sv
// Shared definitions for the "1100" serial recognition path (transmitter, detector, benches).
// Holds the FSM state encoding and the pattern being recognised.
// No logic; the latency and backpressure fields do not apply.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  localparam logic [3:0] MATCH_PAT = 4'b1100;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Bundle of request and serial-output signals for seq_pattern_tx.
// master: requester side (drives start/pattern_in/repeat_in); slave: the transmitter.
// No storage; start is a level sampled by the transmitter only while it is idle.
interface seq_pattern_tx_if #(
  parameter int WIDTH  = 8,
  parameter int REP_W  = 4,
  parameter int MCNT_W = 8
);

  logic              start;
  logic [WIDTH-1:0]  pattern_in;
  logic [REP_W-1:0]  repeat_in;
  logic              seq_out;
  logic              bit_valid;
  logic              busy;
  logic              done;
  logic [MCNT_W-1:0] match_cnt;

  modport master (
    output start, pattern_in, repeat_in,
    input  seq_out, bit_valid, busy, done, match_cnt
  );

  modport slave (
    input  start, pattern_in, repeat_in,
    output seq_out, bit_valid, busy, done, match_cnt
  );

endinterface

// File: rtl/seq_match_counter.sv
// Counts "1100" occurrences in the stream of valid serial bits, with a saturating counter.
// Latency: count reflects a bit on the cycle after that bit is valid.
// No backpressure; clear has priority over counting. Ports: clock, reset, clear, bit_vld/bit_dat in, match_cnt out.
module seq_match_counter
  import seq_pkg::*;
#(
  parameter int MCNT_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              bit_vld,
  input  logic              bit_dat,
  output logic [MCNT_W-1:0] match_cnt
);

  // Last three valid bits, oldest in bit 2. Only valid bits shift in, so gap
  // zeros are invisible and a match may straddle a repetition boundary.
  logic [2:0]        hist_q;
  logic [MCNT_W-1:0] cnt_q;
  logic              hit;

  assign hit = ({hist_q, bit_dat} == MATCH_PAT);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else if (bit_vld) begin
      hist_q <= {hist_q[1:0], bit_dat};
      if (hit && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign match_cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// Shifts a parallel pattern out MSB-first, optionally repeated with zero gaps, and counts "1100" sent.
// Latency: first bit on the cycle after start is accepted; done pulses one cycle after the last bit.
// No backpressure; start is only honoured in IDLE. Ports: clock, reset, bus (slave modport).
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int REP_W   = 4,
  parameter int GAP_LEN = 0,
  parameter int MCNT_W  = 8
) (
  input  logic          clock,
  input  logic          reset,
  seq_pattern_tx_if.slave bus
);

  localparam int BC_W  = $clog2(WIDTH);
  localparam int GAP_W = (GAP_LEN < 1) ? 1 : $clog2(GAP_LEN + 1);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] hold_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [REP_W-1:0] rep_left_q;
  logic [GAP_W-1:0] gap_cnt_q;

  logic start_acc;
  logic last_bit;
  logic more_reps;

  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign last_bit  = (bit_cnt_q == '0);
  assign more_reps = (rep_left_q > REP_W'(1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (!more_reps)       state_d = ST_DONE;
          else if (GAP_LEN > 0) state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_SHIFT;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Counters are tested for their terminal value before being decremented,
  // so they never wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      shreg_q    <= '0;
      hold_q     <= '0;
      bit_cnt_q  <= '0;
      rep_left_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            shreg_q    <= bus.pattern_in;
            hold_q     <= bus.pattern_in;
            rep_left_q <= (bus.repeat_in == '0) ? REP_W'(1) : bus.repeat_in;
            bit_cnt_q  <= BC_W'(WIDTH - 1);
          end
        end
        ST_SHIFT: begin
          shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
          if (!last_bit) begin
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end else if (more_reps) begin
            // Reload on the last bit so the next repetition follows with no
            // bubble, or after the gap when one is configured.
            rep_left_q <= rep_left_q - 1'b1;
            shreg_q    <= hold_q;
            bit_cnt_q  <= BC_W'(WIDTH - 1);
            gap_cnt_q  <= GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Moore outputs, decoded from registers only.
  assign bus.bit_valid = (state_q == ST_SHIFT);
  assign bus.seq_out   = (state_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);

  seq_match_counter #(
    .MCNT_W (MCNT_W)
  ) u_match (
    .clock     (clock),
    .reset     (reset),
    .clear     (start_acc),
    .bit_vld   (bus.bit_valid),
    .bit_dat   (bus.seq_out),
    .match_cnt (bus.match_cnt)
  );

endmodule
